// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores over a word-wide
// synchronous memory, with read-modify-write for partial stores.
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_error,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [2:0] {
        IDLE, READ, CAPT, WRITE, RESP, ERR
    } state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    function automatic logic misaligned(input logic [1:0] sz,
                                        input logic [1:0] a);
        return (sz == 2'b11) ||
               (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a != 2'b00);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  sz,
                                            input logic        sg,
                                            input logic [1:0]  a);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        case (sz)
            2'b00:   return {{24{sg & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{sg & sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Half stores are aligned, so the byte-lane shift also places halves.
    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] wd,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  a);
        logic [31:0] m;
        m = (sz == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
        m = m << {a, 3'b000};
        return (w & ~m) | ((wd << {a, 3'b000}) & m);
    endfunction

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    store_d  = req_store;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_d = ERR;
                    end else if (req_store && req_size == 2'b10) begin
                        state_d     = WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                if (store_q) begin
                    state_d     = WRITE;
                    mem_wdata_d = merge(mem_data_out, wdata_q,
                                        size_q, addr_q[1:0]);
                end else begin
                    state_d    = RESP;
                    rsp_data_d = extract(mem_data_out, size_q,
                                         signed_q, addr_q[1:0]);
                end
            end
            WRITE: state_d = RESP;
            RESP, ERR: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    rsp_data_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP) || (state_d == ERR);
        rsp_error_d = (state_d == ERR);
        mem_en_d    = (state_d == READ) || (state_d == WRITE);
        mem_rw_d    = (state_d == WRITE);
        mem_addr_d  = mem_addr_q;
        if (mem_en_d) begin
            mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_data_q  <= rsp_data_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready      = ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_data       = rsp_data_q;
    assign mem_enable     = mem_en_q;
    assign mem_read_write = mem_rw_q;
    assign mem_address    = mem_addr_q;
    assign mem_data_in    = mem_data_in_w();

    function automatic logic [31:0] mem_data_in_w();
        return mem_wdata_q;
    endfunction

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory,
// response scoreboard, latency/strobe counting and reset abort.
module tb_load_store_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_store = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_error;
    logic          mem_enable;
    logic          mem_read_write;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data_in;
    logic [31:0]   mem_data_out;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .mem_enable     (mem_enable),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out)
    );

    logic [31:0] mem [256];
    logic [7:0]  refb [1024];
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_read_write) begin
                mem[mem_address[9:2]] <= mem_data_in;
                wr_cnt <= wr_cnt + 1;
            end else begin
                mem_data_out <= mem[mem_address[9:2]];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op(input logic st, input logic [1:0] sz,
                      input logic sg, input logic [9:0] a,
                      input logic [31:0] wd, input int hold);
        rsp_t        e;
        logic [31:0] v;
        int          nb, lat, k, rd0, wr0, erd, ewr;
        logic        mis;
        mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
              (sz == 2'd2 && a % 4 != 0);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.err = mis;
        e.data = '0;
        if (mis) begin
            lat = 1; erd = 0; ewr = 0;
        end else if (st) begin
            for (int i = 0; i < nb; i++) refb[a + i] = wd[8*i +: 8];
            lat = (nb == 4) ? 2 : 4;
            erd = (nb == 4) ? 0 : 1;
            ewr = 1;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = refb[a + i];
            if (sg && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hff;
            e.data = v;
            lat = 3; erd = 1; ewr = 0;
        end
        exp_q.push_back(e);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 10'($urandom);
        req_wdata  = $urandom;
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", k, lat);
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_data", rsp_data, e.data);
            @(posedge clk);
            #1;
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reads", rd_cnt - rd0, erd);
        chk("writes", wr_cnt - wr0, ewr);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"},
            {27'd0, req_ready, rsp_valid, rsp_error,
             mem_enable, mem_read_write}, 32'd0);
        chk({tag, "_data"}, rsp_data, 32'd0);
        chk({tag, "_addr"}, {22'd0, mem_address}, 32'd0);
        chk({tag, "_wd"}, mem_data_in, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int          wr0, rd0;
        for (int i = 0; i < 256; i++) begin
            w = (i == 1) ? 32'h9912_7254 :
                (i == 2) ? 32'h1234_5678 : $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) refb[4*i + b] = w[8*b +: 8];
        end

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        op(1'b0, 2'd0, 1'b1, 10'd7, 32'd0, 0);
        op(1'b0, 2'd1, 1'b0, 10'd6, 32'd0, 0);
        op(1'b0, 2'd2, 1'b0, 10'd4, 32'd0, 0);
        op(1'b1, 2'd0, 1'b0, 10'd9, 32'h0000_00ab, 0);
        chk("mem_word8", mem[2], 32'h1234_ab78);
        op(1'b0, 2'd2, 1'b0, 10'd5, 32'd0, 0);
        op(1'b0, 2'd3, 1'b0, 10'd0, 32'd0, 0);
        op(1'b0, 2'd2, 1'b0, 10'd4, 32'd0, 5);
        op(1'b1, 2'd2, 1'b0, 10'd12, 32'hdead_beef, 0);
        op(1'b0, 2'd1, 1'b1, 10'd14, 32'd0, 0);
        op(1'b1, 2'd1, 1'b0, 10'd18, 32'h1234_cafe, 1);
        op(1'b0, 2'd2, 1'b0, 10'd16, 32'd0, 0);
        op(1'b1, 2'd1, 1'b0, 10'd19, 32'h0000_5555, 0);

        for (int n = 0; n < 14; n++) begin
            op(1'($urandom), 2'($urandom), 1'($urandom),
               10'($urandom_range(0, 63)), $urandom,
               $urandom_range(0, 2));
        end

        // Abort a byte store while its read is on the bus.
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_size  = 2'd0;
        req_addr  = 10'd33;
        req_wdata = 32'h0000_00c3;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_read_en", {31'd0, mem_enable}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_outs("abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_reads", rd_cnt - rd0, 0);
        chk("abort_writes", wr_cnt - wr0, 0);
        op(1'b0, 2'd2, 1'b0, 10'd32, 32'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
